// File: rtl/heap_topk_collector.sv
// Captures the sorted word stream emitted by the heap after a flush, checks key ordering,
// then drains the captured list over a valid/ready stream with a last marker.
module heap_topk_collector #(
   parameter int DATA_WIDTH = 8,
   parameter int KEY_WIDTH  = 4,
   parameter int DEPTH      = 8,
   parameter int CNT_WIDTH  = 4,
   parameter int TIMEOUT    = 16,
   parameter int DESCENDING = 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  init,
   input  logic                  flush,
   input  logic                  heap_valid,
   input  logic [DATA_WIDTH-1:0] heap_dout,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  dropped,
   output logic                  order_err,
   output logic                  busy,
   output logic                  done
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [CNT_WIDTH-1:0]  r_wr_ptr;
   logic [CNT_WIDTH-1:0]  r_rd_ptr;
   logic [CNT_WIDTH-1:0]  r_count;
   logic [TW-1:0]         r_timer;
   logic [KEY_WIDTH-1:0]  r_prev_key;
   logic                  r_have_prev;
   logic                  r_dropped;
   logic                  r_order_err;
   logic                  r_m_valid;
   logic                  r_m_last;
   logic [DATA_WIDTH-1:0] r_m_data;
   logic                  r_done;

   logic                  w_accept;
   logic                  w_room;
   logic                  w_timeout;
   logic                  w_empty;
   logic                  w_key_bad;
   logic [KEY_WIDTH-1:0]  w_key;
   logic [CNT_WIDTH-1:0]  w_rd_next;
   logic [CNT_WIDTH-1:0]  w_last_idx;

   assign w_accept   = (r_state == ST_COLLECT) && heap_valid;
   assign w_room     = (r_wr_ptr < CNT_WIDTH'(DEPTH));
   assign w_timeout  = (r_timer == TW'(TIMEOUT - 1));
   assign w_empty    = (r_count == {CNT_WIDTH{1'b0}});
   assign w_key      = heap_dout[KEY_WIDTH-1:0];
   assign w_rd_next  = r_rd_ptr + CNT_WIDTH'(1);
   assign w_last_idx = r_count - CNT_WIDTH'(1);

   // Ordering rule: equal keys are always legal
   always_comb begin
      w_key_bad = 1'b0;
      if (DESCENDING != 0) begin
         w_key_bad = (w_key > r_prev_key);
      end else begin
         w_key_bad = (w_key < r_prev_key);
      end
   end

   // Next-state logic; init overrides everything, including a same-cycle flush
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (flush) begin
               w_next_state = ST_COLLECT;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (!heap_valid && w_timeout) begin
               w_next_state = ST_DRAIN;
            end else begin
               w_next_state = ST_COLLECT;
            end
         end
         ST_DRAIN: begin
            if (w_empty || (r_m_valid && m_ready && r_m_last)) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_DRAIN;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
      if (init) begin
         w_next_state = ST_IDLE;
      end else begin
         w_next_state = w_next_state;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Capture buffer; contents are don't-care outside a collection so no reset
   always_ff @(posedge clk) begin
      if (w_accept && w_room && !init) begin
         r_mem[r_wr_ptr[AW-1:0]] <= heap_dout;
      end
   end

   // Collection bookkeeping, order check and registered drain stream
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr    <= {CNT_WIDTH{1'b0}};
         r_rd_ptr    <= {CNT_WIDTH{1'b0}};
         r_count     <= {CNT_WIDTH{1'b0}};
         r_timer     <= {TW{1'b0}};
         r_prev_key  <= {KEY_WIDTH{1'b0}};
         r_have_prev <= 1'b0;
         r_dropped   <= 1'b0;
         r_order_err <= 1'b0;
         r_m_valid   <= 1'b0;
         r_m_last    <= 1'b0;
         r_m_data    <= {DATA_WIDTH{1'b0}};
         r_done      <= 1'b0;
      end else if (init) begin
         r_wr_ptr    <= {CNT_WIDTH{1'b0}};
         r_rd_ptr    <= {CNT_WIDTH{1'b0}};
         r_count     <= {CNT_WIDTH{1'b0}};
         r_timer     <= {TW{1'b0}};
         r_have_prev <= 1'b0;
         r_dropped   <= 1'b0;
         r_order_err <= 1'b0;
         r_m_valid   <= 1'b0;
         r_m_last    <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (flush) begin
                  r_wr_ptr    <= {CNT_WIDTH{1'b0}};
                  r_rd_ptr    <= {CNT_WIDTH{1'b0}};
                  r_count     <= {CNT_WIDTH{1'b0}};
                  r_timer     <= {TW{1'b0}};
                  r_have_prev <= 1'b0;
                  r_dropped   <= 1'b0;
                  r_order_err <= 1'b0;
               end
            end
            ST_COLLECT: begin
               if (heap_valid) begin
                  r_timer <= {TW{1'b0}};
                  if (w_room) begin
                     r_wr_ptr <= r_wr_ptr + CNT_WIDTH'(1);
                     r_count  <= r_count + CNT_WIDTH'(1);
                  end else begin
                     r_dropped <= 1'b1;
                  end
                  // Dropped words still take part in the order check
                  if (r_have_prev && w_key_bad) begin
                     r_order_err <= 1'b1;
                  end
                  r_prev_key  <= w_key;
                  r_have_prev <= 1'b1;
               end else if (!w_timeout) begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            ST_DRAIN: begin
               if (w_empty) begin
                  r_done <= 1'b1;
               end else if (!r_m_valid) begin
                  r_m_valid <= 1'b1;
                  r_m_data  <= r_mem[r_rd_ptr[AW-1:0]];
                  r_m_last  <= (r_rd_ptr == w_last_idx);
               end else if (m_ready) begin
                  if (r_m_last) begin
                     r_m_valid <= 1'b0;
                     r_m_last  <= 1'b0;
                     r_done    <= 1'b1;
                  end else begin
                     r_rd_ptr <= w_rd_next;
                     r_m_data <= r_mem[w_rd_next[AW-1:0]];
                     r_m_last <= (w_rd_next == w_last_idx);
                  end
               end
            end
            default: begin
               r_m_valid <= 1'b0;
            end
         endcase
      end
   end

   assign m_data    = r_m_data;
   assign m_valid   = r_m_valid;
   assign m_last    = r_m_last;
   assign count     = r_count;
   assign dropped   = r_dropped;
   assign order_err = r_order_err;
   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;

endmodule

// File: tb/tb_heap_topk_collector.sv
// Table-driven bench for heap_topk_collector with a scoreboard of expected drained words.
module tb_heap_topk_collector;

   localparam int DW  = 8;
   localparam int KW  = 4;
   localparam int DEP = 8;
   localparam int CW  = 4;
   localparam int TO  = 16;

   logic          clk;
   logic          rstn;
   logic          init;
   logic          flush;
   logic          heap_valid;
   logic [DW-1:0] heap_dout;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;
   logic [CW-1:0] count;
   logic          dropped;
   logic          order_err;
   logic          busy;
   logic          done;

   heap_topk_collector #(
      .DATA_WIDTH(DW), .KEY_WIDTH(KW), .DEPTH(DEP),
      .CNT_WIDTH(CW), .TIMEOUT(TO), .DESCENDING(1)
   ) dut (
      .clk(clk), .rstn(rstn), .init(init), .flush(flush),
      .heap_valid(heap_valid), .heap_dout(heap_dout),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .count(count), .dropped(dropped), .order_err(order_err),
      .busy(busy), .done(done)
   );

   typedef struct packed {
      logic [3:0]  n;
      logic [79:0] words;
      logic [15:0] rdy;
      logic [3:0]  exp_count;
      logic        exp_drop;
      logic        exp_oerr;
   } vec_t;

   int        total = 0;
   int        bad   = 0;
   int        cyc   = 0;
   int        n_xfer = 0;
   int        n_done = 0;
   int        last_xfer_cyc = 0;
   int        done_cyc = 0;
   int        first_valid_cyc = 0;
   bit        seen_valid = 1'b0;
   string     cur_tag = "reset";
   logic [7:0] sb [$];
   vec_t      tbl [6];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s/%s: got %0h expected %0h", cur_tag, nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output monitor: every valid beat must show the scoreboard head, stalled or not
   always @(negedge clk) begin
      if (rstn) begin
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (m_valid) begin
            if (!seen_valid) begin
               seen_valid = 1'b1;
               first_valid_cyc = cyc;
            end
            if (sb.size() == 0) begin
               check("unexpected_valid", 32'(m_valid), 32'd0);
            end else begin
               check("m_data", 32'(m_data), 32'(sb[0]));
               check("m_last", 32'(m_last), 32'(sb.size() == 1));
               if (m_ready) begin
                  void'(sb.pop_front());
                  n_xfer++;
                  last_xfer_cyc = cyc;
               end
            end
         end
      end
   end

   task automatic run_vec(input vec_t v, input string tag);
      int  x0, d0, c0, nexp, pidx;
      bit  got;
      cur_tag = tag;
      sb.delete();
      nexp = (int'(v.n) > DEP) ? DEP : int'(v.n);
      x0 = n_xfer;
      d0 = n_done;
      seen_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      c0 = cyc;
      for (int i = 0; i < int'(v.n); i++) begin
         heap_valid = 1'b1;
         heap_dout  = v.words[i*8 +: 8];
         if (i < DEP) sb.push_back(heap_dout);
         tick();
      end
      heap_valid = 1'b0;
      heap_dout  = 8'h00;
      got  = 1'b0;
      pidx = 0;
      for (int k = 0; k < 400 && !got; k++) begin
         if (m_valid) begin
            m_ready = v.rdy[pidx];
            pidx = (pidx < 15) ? pidx + 1 : 15;
         end else begin
            m_ready = 1'b1;
         end
         tick();
         if (n_done != d0) got = 1'b1;
      end
      check("done_seen", 32'(got), 32'd1);
      m_ready = 1'b1;
      tick();
      tick();
      check("done_pulses", 32'(n_done - d0), 32'd1);
      check("xfers", 32'(n_xfer - x0), 32'(nexp));
      check("sb_left", 32'(sb.size()), 32'd0);
      check("count", 32'(count), 32'(v.exp_count));
      check("dropped", 32'(dropped), 32'(v.exp_drop));
      check("order_err", 32'(order_err), 32'(v.exp_oerr));
      check("busy_idle", 32'(busy), 32'd0);
      check("m_valid_idle", 32'(m_valid), 32'd0);
      if (nexp > 0) begin
         check("done_after_last", 32'(done_cyc), 32'(last_xfer_cyc + 1));
         check("latency", 32'(first_valid_cyc - c0), 32'(int'(v.n) + TO + 1));
      end
   endtask

   initial begin
      int  x0, d0;
      bit  got;

      tbl[0] = '{n: 4'd5, words: {40'h0, 8'h51, 8'h47, 8'h3C, 8'h2C, 8'h1E},
                 rdy: 16'hFFFF, exp_count: 4'd5, exp_drop: 1'b0, exp_oerr: 1'b0};
      tbl[1] = '{n: 4'd10, words: {8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B, 8'h3C, 8'h2D, 8'h1E, 8'h0F},
                 rdy: 16'hFFFF, exp_count: 4'd8, exp_drop: 1'b1, exp_oerr: 1'b0};
      tbl[2] = '{n: 4'd2, words: {64'h0, 8'h99, 8'h03},
                 rdy: 16'hFFFF, exp_count: 4'd2, exp_drop: 1'b0, exp_oerr: 1'b1};
      tbl[3] = '{n: 4'd4, words: {48'h0, 8'hD2, 8'hC8, 8'hB8, 8'hA9},
                 rdy: 16'hFFE9, exp_count: 4'd4, exp_drop: 1'b0, exp_oerr: 1'b0};
      tbl[4] = '{n: 4'd0, words: 80'h0,
                 rdy: 16'hFFFF, exp_count: 4'd0, exp_drop: 1'b0, exp_oerr: 1'b0};
      tbl[5] = '{n: 4'd9, words: {8'h00, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08},
                 rdy: 16'hFFFF, exp_count: 4'd8, exp_drop: 1'b1, exp_oerr: 1'b1};

      rstn = 1'b0; init = 1'b0; flush = 1'b0;
      heap_valid = 1'b0; heap_dout = 8'h00; m_ready = 1'b1;
      #12;
      cur_tag = "por";
      check("m_valid", 32'(m_valid), 32'd0);
      check("m_last", 32'(m_last), 32'd0);
      check("m_data", 32'(m_data), 32'd0);
      check("count", 32'(count), 32'd0);
      check("busy", 32'(busy), 32'd0);
      check("done", 32'(done), 32'd0);
      check("flags", 32'({dropped, order_err}), 32'd0);
      rstn = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         run_vec(tbl[i], $sformatf("vec%0d", i));
      end

      // Abort in DRAIN after two transfers, then a clean collection
      cur_tag = "abort";
      sb.delete();
      x0 = n_xfer;
      d0 = n_done;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 4; i++) begin
         heap_valid = 1'b1;
         heap_dout  = 8'(8'h44 - 8'(i * 17));
         sb.push_back(heap_dout);
         tick();
      end
      heap_valid = 1'b0;
      m_ready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         tick();
         if (n_xfer - x0 >= 2) got = 1'b1;
      end
      check("two_xfers", 32'(got), 32'd1);
      check("busy_drain", 32'(busy), 32'd1);
      check("valid_drain", 32'(m_valid), 32'd1);
      init = 1'b1;
      m_ready = 1'b0;
      tick();
      init = 1'b0;
      check("m_valid", 32'(m_valid), 32'd0);
      check("m_last", 32'(m_last), 32'd0);
      check("busy", 32'(busy), 32'd0);
      check("count", 32'(count), 32'd0);
      tick();
      check("no_done", 32'(n_done - d0), 32'd0);
      check("still_idle", 32'(m_valid), 32'd0);
      sb.delete();
      m_ready = 1'b1;
      run_vec('{n: 4'd2, words: {64'h0, 8'h7A, 8'h6B}, rdy: 16'hFFFF,
                exp_count: 4'd2, exp_drop: 1'b0, exp_oerr: 1'b0}, "after_abort");

      // init and flush together: init wins
      cur_tag = "init_flush";
      init = 1'b1;
      flush = 1'b1;
      tick();
      init = 1'b0;
      flush = 1'b0;
      check("busy", 32'(busy), 32'd0);

      // Async reset mid-COLLECT
      cur_tag = "reset_mid";
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         heap_valid = 1'b1;
         heap_dout  = 8'(8'h39 - 8'(i * 4));
         tick();
      end
      heap_valid = 1'b0;
      tick();
      check("count_before", 32'(count), 32'd3);
      check("busy_before", 32'(busy), 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      check("busy", 32'(busy), 32'd0);
      check("count", 32'(count), 32'd0);
      check("m_valid", 32'(m_valid), 32'd0);
      check("m_data", 32'(m_data), 32'd0);
      check("flags", 32'({dropped, order_err, done}), 32'd0);
      tick();
      rstn = 1'b1;
      tick();
      check("busy_after", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
